// File: rtl/phase_wrapper.sv
// Phase accumulator with wrap to [-PI, PI-1] and a signed turn counter.
// Two-stage pipeline: stage 1 clamps the increment, stage 2 accumulates,
// wraps and serves as the output register. Both stages share one enable.
module phase_wrapper #(
  parameter int DIN_WIDTH  = 16,
  parameter int TURN_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         acc_on,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [DIN_WIDTH:0]    freq_in,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic signed [DIN_WIDTH-1:0]  phase_out,
  output logic signed [TURN_WIDTH-1:0] turns,
  output logic                         err
);

  localparam int SW = DIN_WIDTH + 2;

  localparam logic signed [DIN_WIDTH:0] PI_F    = (DIN_WIDTH+1)'(2**(DIN_WIDTH-3));
  localparam logic signed [DIN_WIDTH:0] NEG_PI_F = -PI_F;
  localparam logic signed [SW-1:0]      PI_S    = SW'(2**(DIN_WIDTH-3));
  localparam logic signed [SW-1:0]      NEG_PI_S = -PI_S;
  localparam logic signed [SW-1:0]      TWOPI_S = SW'(2**(DIN_WIDTH-2));
  localparam logic signed [TURN_WIDTH-1:0] ONE_T = TURN_WIDTH'(1);

  // Stage-1 payload: clamped increment plus the acc_on seen with the beat.
  typedef struct packed {
    logic signed [DIN_WIDTH:0] inc;
    logic                      acc;
  } s1_t;

  logic [1:0] vld_pipe;   // [0] stage 1, [1] stage 2 (= m_valid)
  logic       en;
  s1_t        s1;

  logic signed [DIN_WIDTH:0]    inc_c;
  logic                         over;
  logic signed [SW-1:0]         sum;
  logic signed [SW-1:0]         wrapped;
  logic signed [TURN_WIDTH-1:0] nxt_turns;

  assign en      = !vld_pipe[1] || m_ready;
  assign s_ready = en;
  assign m_valid = vld_pipe[1];

  // Clamp the incoming increment to [-PI, PI] and flag out-of-range input.
  always_comb begin
    inc_c = freq_in;
    over  = 1'b0;
    if (freq_in > PI_F) begin
      inc_c = PI_F;
      over  = 1'b1;
    end else if (freq_in < NEG_PI_F) begin
      inc_c = NEG_PI_F;
      over  = 1'b1;
    end
  end

  // Stage 1 register: capture a new beat, or go empty when advancing without one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[0] <= 1'b0;
      s1          <= '0;
    end else if (en) begin
      vld_pipe[0] <= s_valid;
      s1.inc      <= inc_c;
      s1.acc      <= acc_on;
    end
  end

  // Sticky range error; clr wins over a same-cycle set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    err <= 1'b0;
    else if (clr)                  err <= 1'b0;
    else if (s_valid && en && over) err <= 1'b1;
  end

  // Widened sum cannot overflow; fold back by one turn in either direction.
  always_comb begin
    sum       = {{2{phase_out[DIN_WIDTH-1]}}, phase_out} + {s1.inc[DIN_WIDTH], s1.inc};
    wrapped   = sum;
    nxt_turns = turns;
    if (sum >= PI_S) begin
      wrapped   = sum - TWOPI_S;
      nxt_turns = turns + ONE_T;
    end else if (sum < NEG_PI_S) begin
      wrapped   = sum + TWOPI_S;
      nxt_turns = turns - ONE_T;
    end
  end

  // Stage 2 / output register: clr overrides accumulation, valid bit untouched by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      phase_out   <= '0;
      turns       <= '0;
    end else begin
      if (en) vld_pipe[1] <= vld_pipe[0];
      if (clr) begin
        phase_out <= '0;
        turns     <= '0;
      end else if (en && vld_pipe[0] && s1.acc) begin
        phase_out <= wrapped[DIN_WIDTH-1:0];
        turns     <= nxt_turns;
      end
    end
  end

endmodule

// File: tb/tb_phase_wrapper.sv
// Scoreboard bench for phase_wrapper: expected phase/turns pushed on accept,
// popped and compared when the output beat is taken.
module tb_phase_wrapper;
  localparam int DW = 16;
  localparam int TW = 4;   // narrow turn counter so modulo wrap is reachable

  logic                 clk = 1'b0;
  logic                 rst_n, clr, acc_on, s_valid, s_ready, m_valid, m_ready, err;
  logic signed [DW:0]   freq_in;
  logic signed [DW-1:0] phase_out;
  logic signed [TW-1:0] turns;

  phase_wrapper #(.DIN_WIDTH(DW), .TURN_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .acc_on(acc_on),
    .s_valid(s_valid), .s_ready(s_ready), .freq_in(freq_in),
    .m_valid(m_valid), .m_ready(m_ready),
    .phase_out(phase_out), .turns(turns), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                   ph;
    logic signed [TW-1:0] tr;
  } exp_t;

  exp_t q[$];
  int                   m_ph;
  logic signed [TW-1:0] m_tr;
  logic                 m_err;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor on the falling edge: compare taken beats, then model accepted ones.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_ph = 0; m_tr = '0; m_err = 1'b0;
    end else begin
      if (m_valid && m_ready) begin
        if (q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("phase", int'(phase_out), e.ph);
          chk("turns", int'(turns), int'(e.tr));
          chk("err", int'(err), int'(m_err));
        end
      end
      if (clr) begin
        for (int i = 0; i < q.size(); i++) begin q[i].ph = 0; q[i].tr = '0; end
        m_ph = 0; m_tr = '0; m_err = 1'b0;
      end
      if (s_valid && s_ready) begin
        int f, s;
        exp_t e;
        f = int'(freq_in);
        if (f > 8192) begin f = 8192; m_err = 1'b1; end
        else if (f < -8192) begin f = -8192; m_err = 1'b1; end
        if (acc_on) begin
          s = m_ph + f;
          if (s >= 8192) begin s = s - 16384; m_tr = m_tr + TW'(1); end
          else if (s < -8192) begin s = s + 16384; m_tr = m_tr - TW'(1); end
          m_ph = s;
        end
        e.ph = m_ph; e.tr = m_tr;
        q.push_back(e);
      end
    end
  end

  task automatic send(input int f);
    int n;
    logic ok;
    n = 0;
    s_valid = 1'b1;
    freq_in = (DW+1)'(f);
    do begin
      @(negedge clk); ok = s_ready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 100);
    if (!ok) chk("send_timeout", 0, 1);
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 500) begin @(posedge clk); #1; n++; end
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; acc_on = 1'b1; s_valid = 1'b0; m_ready = 1'b1; freq_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mvalid", int'(m_valid), 0);
    chk("rst_phase", int'(phase_out), 0);
    chk("rst_turns", int'(turns), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_rst", int'(s_ready), 1);

    // Nine steps of 1000: the ninth crosses PI.
    for (int i = 0; i < 9; i++) send(1000);
    drain();
    chk("ramp_phase", int'(phase_out), -7384);
    chk("ramp_turns", int'(turns), 1);
    pulse_clr();
    chk("clr_phase", int'(phase_out), 0);

    // -PI holds, second -PI wraps down.
    send(-8192); send(-8192);
    drain();
    chk("neg_phase", int'(phase_out), 0);
    chk("neg_turns", int'(turns), -1);
    pulse_clr();

    // Out-of-range increment: clamp to PI, which wraps to -PI.
    send(20000);
    drain();
    chk("clamp_err", int'(err), 1);
    chk("clamp_phase", int'(phase_out), -8192);
    chk("clamp_turns", int'(turns), 1);
    pulse_clr();
    chk("clr_err", int'(err), 0);
    chk("clr_phase2", int'(phase_out), 0);
    chk("clr_turns2", int'(turns), 0);

    // clr coincides with the stage-2 update of a beat.
    send(300);
    pulse_clr();
    chk("clrhit_valid", int'(m_valid), 1);
    chk("clrhit_phase", int'(phase_out), 0);
    send(300);
    drain();
    chk("after_clr_phase", int'(phase_out), 300);

    // acc_on low: beats flow, phase holds.
    acc_on = 1'b0;
    for (int i = 0; i < 3; i++) send(500);
    drain();
    chk("hold_phase", int'(phase_out), 300);
    acc_on = 1'b1;

    // Backpressure: both stages fill, ready drops, outputs hold.
    m_ready = 1'b0; s_valid = 1'b1; freq_in = 17'sd100;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      freq_in = freq_in + 17'sd50;
      if (i >= 1) begin
        chk("stall_ready", int'(s_ready), 0);
        chk("stall_valid", int'(m_valid), 1);
        chk("stall_phase", int'(phase_out), q[0].ph);
      end
    end
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; freq_in = freq_in + 17'sd50; end
    s_valid = 1'b0;
    drain();

    // Reset in the middle of a stream.
    s_valid = 1'b1; freq_in = 17'sd200;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(m_valid), 0);
    chk("midrst_phase", int'(phase_out), 0);
    chk("midrst_turns", int'(turns), 0);
    chk("midrst_err", int'(err), 0);
    s_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(5);
    chk("lat_cycle1", int'(m_valid), 0);
    @(posedge clk); #1;
    chk("lat_cycle2", int'(m_valid), 1);
    chk("lat_phase", int'(phase_out), 5);
    drain();

    // Random traffic with random backpressure and acc_on.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      s_valid = 1'($urandom_range(0, 1));
      m_ready = ($urandom_range(0, 3) != 0);
      acc_on  = ($urandom_range(0, 7) != 0);
      freq_in = (DW+1)'(int'($urandom_range(0, 20000)) - 10000);
    end
    s_valid = 1'b0; m_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/phase_wrapper.md
PHASE_WRAPPER -- requirements
Module: phase_wrapper

Interface
REQ-001 Parameter DIN_WIDTH, default 16: wrapped phase width in scaled radians; PI = 2^(DIN_WIDTH-3), TWOPI = 2^(DIN_WIDTH-2).
REQ-002 Parameter TURN_WIDTH, default 16: width of the signed turn counter.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 clr  in  1  synchronous clear of accumulator and turn counter.
REQ-006 acc_on  in  1  1 = accumulate accepted increments; 0 = pass beats without changing phase.
REQ-007 s_valid  in  1  input beat valid.
REQ-008 s_ready  out  1  input beat accepted when s_valid and s_ready are both high.
REQ-009 freq_in  in  DIN_WIDTH+1 signed  phase increment per beat, scaled radians.
REQ-010 m_valid  out  1  output beat valid.
REQ-011 m_ready  in  1  downstream accepts output beat.
REQ-012 phase_out  out  DIN_WIDTH signed  wrapped phase, range [-PI, PI-1].
REQ-013 turns  out  TURN_WIDTH signed  net count of wraps (+1 per upward wrap, -1 per downward wrap).
REQ-014 err  out  1  sticky flag: an accepted freq_in lay outside [-PI, PI].

Function
REQ-015 Pipeline: stage 1 (clamp) and stage 2 (accumulate/wrap, the output register); both stages advance on en = !m_valid || m_ready.
REQ-016 s_ready SHALL equal en; no beat is dropped or duplicated under any m_ready pattern.
REQ-017 Latency: accepted beat appears on m_valid exactly 2 cycles later when m_ready is held high; throughput 1 beat/cycle.
REQ-018 Stage 1: freq_in > PI is clamped to PI, freq_in < -PI is clamped to -PI, and err is set; in-range values pass unchanged.
REQ-019 Stage 2, on an advancing valid beat with acc_on=1: s = phase_out + clamped increment, computed at DIN_WIDTH+2 bits, no overflow.
REQ-020 If s >= PI: phase_out <= s - TWOPI, turns <= turns + 1; if s < -PI: phase_out <= s + TWOPI, turns <= turns - 1; otherwise phase_out <= s.
REQ-021 Boundaries: s = PI wraps to -PI; s = -PI does not wrap.
REQ-022 With acc_on=0 the beat still propagates to m_valid; phase_out and turns hold.
REQ-023 turns wraps modulo 2^TURN_WIDTH with no saturation.
REQ-024 phase_out, turns and m_valid SHALL hold while m_valid=1 and m_ready=0.
REQ-025 clr=1: phase_out <= 0 and turns <= 0, taking priority over any stage-2 update in the same cycle; err is cleared; pipeline valid bits are unaffected.
REQ-026 The stage-1 valid bit SHALL be set by an accepted beat and cleared when stage 1 advances without a new beat.

Reset
REQ-027 rst_n low SHALL immediately force phase_out=0, turns=0, err=0, m_valid=0 and stage-1 valid=0, and discard all in-flight beats.
REQ-028 After rst_n deasserts, s_ready=1 from the first clock edge.

Verification (DIN_WIDTH=16: PI=8192, TWOPI=16384)
REQ-029 Assert rst_n low mid-stream -> all outputs 0 at once; after release, the first beat with freq_in=5 gives phase_out=5 two cycles later.
REQ-030 freq_in=1000, 9 beats, acc_on=1, m_ready=1 -> phase_out 1000..8000 on beats 1-8, beat 9 gives -7384 and turns=1.
REQ-031 freq_in=-8192 twice from 0 -> phase_out=-8192 with turns=0, then phase_out=0 with turns=-1.
REQ-032 freq_in=20000 from 0 -> clamped to 8192, giving phase_out=-8192, turns=1, err=1; clr then gives err=0, phase_out=0, turns=0.
REQ-033 s_valid held high, m_ready low for 5 cycles -> s_ready drops once both stages are full; after release, all beats emerge in order with the correct sums.
REQ-034 clr asserted in the same cycle a beat with freq_in=300 updates stage 2 -> phase_out=0, turns=0; the next beat with freq_in=300 gives 300.
